vec_load_sequencer: RTL and testbench

- Sits directly upstream of the image data memory in the vector CPU.
- Walks the 96x96 8-bit image in 8-pixel vectors and drives the memory's 16-bit byte address.
- Captures the memory's 16-lane x 16-bit read bus and hands one vector at a time to the vector register file writeback over a valid/ready handshake.
- Flags any vector that reaches past the end of the image.

---
 rtl/vec_mem_pkg.sv | 22 ++
 rtl/vec_lane_capture.sv | 30 +++
 rtl/vec_load_sequencer.sv | 104 ++++++++++
 tb/tb_vec_load_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and geometry for the vector load sequencer
package vec_mem_pkg;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int LANES        = 16;
    localparam int ACTIVE_LANES = 8;
    localparam int IMAGE_WIDTH  = 96;
    localparam int IMAGE_HEIGHT = 96;
    localparam int IMG_BYTES    = IMAGE_WIDTH * IMAGE_HEIGHT;

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;
    typedef logic [ADDR_W-1:0]            addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/vec_lane_capture.sv
// rtl/vec_lane_capture.sv - lane mask and image bounds check on the memory read bus
module vec_lane_capture
    import vec_mem_pkg::*;
(
    input  vec_t  mem_rd,
    input  addr_t cur_addr,
    output vec_t  vec,
    output logic  oob
);

    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(IMG_BYTES - 1);

    logic [ADDR_W:0] lane_addr;

    // One extra address bit so a vector straddling 0xFFFF counts as past the image, not wrapped.
    always_comb begin
        vec       = '0;
        oob       = 1'b0;
        lane_addr = '0;
        for (int i = 0; i < ACTIVE_LANES; i++) begin
            lane_addr = {1'b0, cur_addr} + (ADDR_W+1)'(i);
            if (lane_addr > LAST_BYTE) begin
                oob = 1'b1;
            end else begin
                vec[i] = mem_rd[i];
            end
        end
    end

endmodule

// File: rtl/vec_load_sequencer.sv
// rtl/vec_load_sequencer.sv - walks the image memory and hands out one 8-byte vector per handshake
module vec_load_sequencer
    import vec_mem_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  start,
    input  addr_t base_addr,
    input  addr_t stride,
    input  addr_t count,
    output logic  busy,
    output logic  done,
    output addr_t mem_addr,
    input  vec_t  mem_rd,
    output vec_t  vec_data,
    output logic  vec_valid,
    input  logic  vec_ready,
    output addr_t vec_index,
    output logic  err_oob
);

    seq_state_t state, state_next;

    addr_t cur_addr;
    addr_t stride_q;
    addr_t remaining;
    addr_t index_q;
    vec_t  data_q;
    logic  oob_q;

    vec_t  cap_vec;
    logic  cap_oob;

    vec_lane_capture u_capture (
        .mem_rd   (mem_rd),
        .cur_addr (cur_addr),
        .vec      (cap_vec),
        .oob      (cap_oob)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (count == '0) ? DONE : FETCH;
            FETCH:   state_next = PRESENT;
            PRESENT: if (vec_ready) state_next = (remaining == addr_t'(1)) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_addr  <= '0;
            stride_q  <= '0;
            remaining <= '0;
            index_q   <= '0;
            data_q    <= '0;
            oob_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        stride_q  <= stride;
                        remaining <= count;
                        index_q   <= '0;
                        oob_q     <= 1'b0;
                    end
                end
                FETCH: begin
                    data_q <= cap_vec;
                    if (cap_oob) oob_q <= 1'b1;
                end
                PRESENT: begin
                    // On the final handshake the address is left alone so mem_addr stays on the last vector.
                    if (vec_ready && remaining != addr_t'(1)) begin
                        remaining <= remaining - addr_t'(1);
                        index_q   <= index_q + addr_t'(1);
                        cur_addr  <= cur_addr + stride_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign vec_valid = (state == PRESENT);
    assign mem_addr  = cur_addr;
    assign vec_data  = data_q;
    assign vec_index = index_q;
    assign err_oob   = oob_q;

endmodule

// File: tb/tb_vec_load_sequencer.sv
// tb/tb_vec_load_sequencer.sv - directed self-checking bench for vec_load_sequencer
module tb_vec_load_sequencer;
    import vec_mem_pkg::*;

    logic  CLK;
    logic  RST_N;
    logic  start;
    addr_t base_addr;
    addr_t stride;
    addr_t count;
    logic  busy;
    logic  done;
    addr_t mem_addr;
    vec_t  mem_rd;
    vec_t  vec_data;
    logic  vec_valid;
    logic  vec_ready;
    addr_t vec_index;
    logic  err_oob;

    int checks = 0;
    int errors = 0;

    vec_load_sequencer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .vec_data  (vec_data),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_index (vec_index),
        .err_oob   (err_oob)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: byte a holds the value a, so lane i reads mem_addr+i.
    always_comb begin
        for (int i = 0; i < LANES; i++) mem_rd[i] = mem_addr + 16'(i);
    end

    function automatic vec_t exp_vec(input logic [15:0] base);
        vec_t v;
        logic [16:0] a;
        v = '0;
        for (int i = 0; i < ACTIVE_LANES; i++) begin
            a = {1'b0, base} + 17'(i);
            if (a <= 17'd9215) v[i] = base + 16'(i);
        end
        return v;
    endfunction

    task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [15:0] c);
        @(posedge CLK); #1;
        start = 1'b1; base_addr = b; stride = s; count = c;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, vec_valid, err_oob} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, vec_valid, err_oob});
        end
        checks++;
        if (mem_addr !== 16'h0 || vec_index !== 16'h0 || vec_data !== '0) begin
            errors++; $display("FAIL reset_regs mem_addr %h vec_index %h vec_data %h want 0", mem_addr, vec_index, vec_data);
        end
    endtask

    task automatic test_basic;
        vec_ready = 1'b1;
        do_start(16'd0, 16'd8, 16'd3);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK);
            checks++;
            if (vec_valid !== (cyc == 2 || cyc == 4 || cyc == 6)) begin
                errors++; $display("FAIL basic_valid cyc %0d got %b", cyc, vec_valid);
            end
            if (cyc == 2 || cyc == 4 || cyc == 6) begin
                checks++;
                if (vec_data !== exp_vec(16'((cyc/2 - 1) * 8)) || vec_index !== 16'(cyc/2 - 1)) begin
                    errors++; $display("FAIL basic_vec cyc %0d data %h idx %0d want %h idx %0d",
                                       cyc, vec_data, vec_index, exp_vec(16'((cyc/2 - 1) * 8)), cyc/2 - 1);
                end
            end
            checks++;
            if (done !== (cyc == 7) || busy !== (cyc <= 7)) begin
                errors++; $display("FAIL basic_done cyc %0d done %b busy %b want %b %b", cyc, done, busy, cyc == 7, cyc <= 7);
            end
        end
    endtask

    task automatic test_backpressure;
        vec_ready = 1'b1;
        do_start(16'd0, 16'd8, 16'd3);
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_index !== 16'd0 || vec_data !== exp_vec(16'd0)) begin
            errors++; $display("FAIL bp_v0 valid %b idx %0d data %h", vec_valid, vec_index, vec_data);
        end
        @(posedge CLK); #1;
        vec_ready = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if (vec_valid !== 1'b1 || vec_index !== 16'd1 || vec_data !== exp_vec(16'd8) || mem_addr !== 16'd8) begin
                errors++; $display("FAIL bp_hold k %0d valid %b idx %0d addr %0d data %h want 1 1 8 %h",
                                   k, vec_valid, vec_index, mem_addr, vec_data, exp_vec(16'd8));
            end
        end
        vec_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b0 || mem_addr !== 16'd16) begin
            errors++; $display("FAIL bp_fetch2 valid %b addr %0d want 0 16", vec_valid, mem_addr);
        end
        @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_index !== 16'd2 || vec_data !== exp_vec(16'd16)) begin
            errors++; $display("FAIL bp_v2 valid %b idx %0d data %h", vec_valid, vec_index, vec_data);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL bp_done got %b want 1", done);
        end
    endtask

    task automatic test_bounds;
        vec_ready = 1'b1;
        do_start(16'd9210, 16'd8, 16'd1);
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_data[5] !== 16'd9215 || vec_data[0] !== 16'd9210 ||
            vec_data[6] !== 16'd0 || vec_data[7] !== 16'd0 || vec_data !== exp_vec(16'd9210)) begin
            errors++; $display("FAIL bounds_vec valid %b data %h want %h", vec_valid, vec_data, exp_vec(16'd9210));
        end
        checks++;
        if (err_oob !== 1'b1) begin
            errors++; $display("FAIL bounds_oob got %b want 1", err_oob);
        end
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (err_oob !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bounds_sticky oob %b busy %b want 1 0", err_oob, busy);
        end
        do_start(16'd0, 16'd8, 16'd1);
        @(negedge CLK);
        checks++;
        if (err_oob !== 1'b0) begin
            errors++; $display("FAIL bounds_clear got %b want 0", err_oob);
        end
        @(negedge CLK); @(negedge CLK); @(negedge CLK);
    endtask

    task automatic test_zero_count;
        vec_ready = 1'b1;
        do_start(16'd40, 16'd8, 16'd0);
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || vec_valid !== 1'b0) begin
            errors++; $display("FAIL zero_c1 done %b busy %b valid %b want 1 1 0", done, busy, vec_valid);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || vec_valid !== 1'b0) begin
            errors++; $display("FAIL zero_c2 done %b busy %b valid %b want 0 0 0", done, busy, vec_valid);
        end
    endtask

    task automatic test_wrap;
        vec_ready = 1'b1;
        do_start(16'hFFF8, 16'd16, 16'd2);
        @(negedge CLK);
        checks++;
        if (mem_addr !== 16'hFFF8) begin
            errors++; $display("FAIL wrap_addr0 got %h want fff8", mem_addr);
        end
        @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== '0 || err_oob !== 1'b1) begin
            errors++; $display("FAIL wrap_v0 valid %b data %h oob %b want 1 0 1", vec_valid, vec_data, err_oob);
        end
        @(negedge CLK);
        checks++;
        if (mem_addr !== 16'h0008) begin
            errors++; $display("FAIL wrap_addr1 got %h want 0008", mem_addr);
        end
        @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_index !== 16'd1 || vec_data !== exp_vec(16'd8)) begin
            errors++; $display("FAIL wrap_v1 valid %b idx %0d data %h", vec_valid, vec_index, vec_data);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL wrap_done got %b want 1", done);
        end
    endtask

    task automatic test_reset_mid;
        vec_ready = 1'b1;
        do_start(16'd0, 16'd8, 16'd4);
        @(negedge CLK); @(negedge CLK);
        @(posedge CLK); #1;
        vec_ready = 1'b0;
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_index !== 16'd1) begin
            errors++; $display("FAIL rmid_pre valid %b idx %0d want 1 1", vec_valid, vec_index);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({busy, done, vec_valid, err_oob} !== 4'b0 || mem_addr !== 16'h0 ||
            vec_index !== 16'h0 || vec_data !== '0) begin
            errors++; $display("FAIL rmid_reset flags %b addr %h idx %h data %h want all 0",
                               {busy, done, vec_valid, err_oob}, mem_addr, vec_index, vec_data);
        end
        #2;
        RST_N = 1'b1;
        vec_ready = 1'b1;
        do_start(16'd100, 16'd8, 16'd1);
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (vec_valid !== 1'b1 || vec_index !== 16'd0 || vec_data !== exp_vec(16'd100)) begin
            errors++; $display("FAIL rmid_vec valid %b idx %0d data %h want %h", vec_valid, vec_index, vec_data, exp_vec(16'd100));
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL rmid_done got %b want 1", done);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        start = 1'b0;
        base_addr = '0;
        stride = '0;
        count = '0;
        vec_ready = 1'b0;
        @(negedge CLK);
        test_reset;
        @(negedge CLK);
        RST_N = 1'b1;
        test_basic;
        test_backpressure;
        test_bounds;
        test_zero_count;
        test_wrap;
        test_reset_mid;
        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
